// File: rtl/tile_gfx_pkg.sv
// Shared definitions for the tile graphics blocks: sequencer states and
// a width helper that never returns a zero-width field.
package tile_gfx_pkg;

    typedef enum logic [2:0] {
        BOOT,
        INIT_DRAW,
        IDLE,
        FLASH_DRAW,
        HOLD,
        RESTORE_DRAW
    } state_t;

    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/tile_raster_counter.sv
// Raster scan counter for one tile: walks px across each row and py down the
// tile, flags the final pixel, and can be cleared at any time.
module tile_raster_counter
    import tile_gfx_pkg::*;
#(
    parameter int TILE_W = 16,
    parameter int TILE_H = 16
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           clear,
    input  logic                           enable,
    output logic [clog2_min1(TILE_W)-1:0]  px,
    output logic [clog2_min1(TILE_H)-1:0]  py,
    output logic                           last
);

    localparam int XW = clog2_min1(TILE_W);
    localparam int YW = clog2_min1(TILE_H);
    localparam logic [XW-1:0] X_LAST = XW'(TILE_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(TILE_H - 1);

    assign last = (px == X_LAST) && (py == Y_LAST);

    // Advance one pixel per enabled cycle, wrapping rows and the whole tile.
    always_ff @(posedge clock) begin
        if (!resetn || clear) begin
            px <= '0;
            py <= '0;
        end else if (enable) begin
            if (px == X_LAST) begin
                px <= '0;
                py <= (py == Y_LAST) ? '0 : py + YW'(1);
            end else begin
                px <= px + XW'(1);
            end
        end
    end

endmodule

// File: rtl/tile_flash_sequencer.sv
// Tile flash sequencer: draws every tile in the base colour after start,
// then services flash requests by drawing the tile in the flash colour,
// holding it for a fixed time and redrawing it in the base colour.
module tile_flash_sequencer
    import tile_gfx_pkg::*;
#(
    parameter int NUM_TILES   = 4,
    parameter int TILE_W      = 16,
    parameter int TILE_H      = 16,
    parameter int HOLD_CYCLES = 1000
) (
    input  logic                              clock,
    input  logic                              resetn,
    input  logic                              start,
    input  logic                              req_valid,
    input  logic [clog2_min1(NUM_TILES)-1:0]  req_tile,
    output logic                              req_ready,
    output logic [clog2_min1(NUM_TILES)-1:0]  tile_num,
    output logic [clog2_min1(TILE_W)-1:0]     px,
    output logic [clog2_min1(TILE_H)-1:0]     py,
    output logic                              flash,
    output logic                              plot,
    output logic                              busy,
    output logic                              done
);

    localparam int TW = clog2_min1(NUM_TILES);
    localparam int HW = clog2_min1(HOLD_CYCLES);
    localparam logic [TW-1:0] LAST_TILE     = TW'(NUM_TILES - 1);
    localparam logic [TW:0]   NUM_TILES_EXT = (TW + 1)'(NUM_TILES);
    localparam logic [HW-1:0] HOLD_LOAD     = HW'(HOLD_CYCLES - 1);

    state_t          state;
    state_t          next_state;
    logic [HW-1:0]   hold_cnt;
    logic            last_pixel;
    logic            tile_ok;
    logic            state_change;

    assign tile_ok      = ({1'b0, req_tile} < NUM_TILES_EXT);
    assign state_change = (next_state != state);

    tile_raster_counter #(
        .TILE_W (TILE_W),
        .TILE_H (TILE_H)
    ) u_raster (
        .clock  (clock),
        .resetn (resetn),
        .clear  (state_change),
        .enable (plot),
        .px     (px),
        .py     (py),
        .last   (last_pixel)
    );

    // State register; reset always returns to BOOT and abandons any draw.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= BOOT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and the state-derived strobes.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        plot       = 1'b0;
        flash      = 1'b0;
        busy       = 1'b1;
        case (state)
            BOOT: begin
                busy = 1'b0;
                if (start) next_state = INIT_DRAW;
            end
            INIT_DRAW: begin
                plot = 1'b1;
                if (last_pixel && (tile_num == LAST_TILE)) next_state = IDLE;
            end
            IDLE: begin
                busy      = 1'b0;
                req_ready = 1'b1;
                if (req_valid && tile_ok) next_state = FLASH_DRAW;
            end
            FLASH_DRAW: begin
                plot  = 1'b1;
                flash = 1'b1;
                if (last_pixel) next_state = HOLD;
            end
            HOLD: begin
                if (hold_cnt == '0) next_state = RESTORE_DRAW;
            end
            RESTORE_DRAW: begin
                plot = 1'b1;
                if (last_pixel) next_state = IDLE;
            end
            default: next_state = BOOT;
        endcase
    end

    // Tile selection, hold countdown (loaded on HOLD entry, cleared on any
    // other entry) and the completion pulse for the first IDLE cycle.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            tile_num <= '0;
            hold_cnt <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state == RESTORE_DRAW) && last_pixel;
            case (state)
                BOOT:      if (start) tile_num <= '0;
                INIT_DRAW: if (last_pixel && (tile_num != LAST_TILE)) tile_num <= tile_num + TW'(1);
                IDLE:      if (req_valid && tile_ok) tile_num <= req_tile;
                default:   tile_num <= tile_num;
            endcase
            if (state_change) begin
                hold_cnt <= (next_state == HOLD) ? HOLD_LOAD : '0;
            end else if ((state == HOLD) && (hold_cnt != '0)) begin
                hold_cnt <= hold_cnt - HW'(1);
            end
        end
    end

endmodule

// File: doc/tile_flash_sequencer.md
TILE_FLASH_SEQUENCER -- requirements
Module: tile_flash_sequencer

Interface
REQ-001 Parameter NUM_TILES, default 4, number of tiles on screen (>=2).
REQ-002 Parameter TILE_W, default 16, tile width in pixels (>=1).
REQ-003 Parameter TILE_H, default 16, tile height in pixels (>=1).
REQ-004 Parameter HOLD_CYCLES, default 1000, cycles the flash colour stays on screen before restore (>=1).
REQ-005 Derived widths: TW = max(1, clog2(NUM_TILES)), XW = max(1, clog2(TILE_W)), YW = max(1, clog2(TILE_H)).
REQ-006 clock  in  1  system clock, all state updates on posedge.
REQ-007 resetn  in  1  reset, synchronous, active-low.
REQ-008 start  in  1  active-high; starts the boot draw of all tiles.
REQ-009 req_valid  in  1  flash request valid.
REQ-010 req_tile  in  TW  index of tile to flash.
REQ-011 req_ready  out  1  high only in IDLE; transfer when req_valid && req_ready at a posedge.
REQ-012 tile_num  out  TW  tile currently being drawn.
REQ-013 px  out  XW  pixel column within the tile.
REQ-014 py  out  YW  pixel row within the tile.
REQ-015 flash  out  1  colour select: 1 = flash colour, 0 = base colour.
REQ-016 plot  out  1  pixel write enable for the frame buffer.
REQ-017 busy  out  1  high in every state except BOOT and IDLE.
REQ-018 done  out  1  one-cycle pulse on completion of a restore draw.

Function
REQ-019 The FSM states shall be BOOT, INIT_DRAW, IDLE, FLASH_DRAW, HOLD and RESTORE_DRAW.
REQ-020 BOOT -> INIT_DRAW when start=1, with tile_num=0 and px=py=0.
REQ-021 In every draw state, plot=1 each cycle; px increments; at px=TILE_W-1, px wraps to 0 and py increments.
REQ-022 A tile is finished at the cycle where px=TILE_W-1 and py=TILE_H-1, giving exactly TILE_W*TILE_H plot cycles per tile.
REQ-023 INIT_DRAW uses flash=0 and draws tiles 0 to NUM_TILES-1 in order; after the last pixel of tile NUM_TILES-1 it goes to IDLE.
REQ-024 IDLE: req_ready=1 and plot=0; on transfer, req_tile is latched into tile_num and the FSM goes to FLASH_DRAW, whose first plot is in the cycle after the transfer.
REQ-025 A transfer with req_tile >= NUM_TILES shall be consumed and discarded: the FSM stays in IDLE, with no plot and no done.
REQ-026 FLASH_DRAW draws tile_num with flash=1, then goes to HOLD.
REQ-027 HOLD lasts exactly HOLD_CYCLES cycles with plot=0, using an internal down-counter, then goes to RESTORE_DRAW.
REQ-028 RESTORE_DRAW draws the same tile_num with flash=0; on its last pixel it goes to IDLE and done=1 in the following cycle, the first IDLE cycle.
REQ-029 Latency from transfer edge to done shall be 2*TILE_W*TILE_H + HOLD_CYCLES + 1 cycles.
REQ-030 While busy, req_valid is ignored; a held request is accepted in the IDLE cycle that follows completion.
REQ-031 start is ignored outside BOOT.
REQ-032 px, py and the hold counter are cleared on every state entry.

Reset
REQ-033 When resetn=0 at a posedge: state=BOOT, tile_num=0, px=py=0, hold counter=0, flash=0, plot=0, done=0, busy=0, req_ready=0.
REQ-034 Reset mid-draw or mid-hold shall abort immediately; no partial restore is attempted.

Structure
REQ-035 State encodings and the width helper (clog2 with minimum 1) shall live in shared package tile_gfx_pkg.
REQ-036 A single sub-module, tile_raster_counter (px/py scan, clear, enable, last-pixel flag), shall be instantiated once.

Verification
REQ-037 NUM_TILES=4, W=4, H=2: start=1 -> 32 consecutive plot cycles with tile_num 0,1,2,3 (8 each), flash=0; then req_ready=1.
REQ-038 Same params, HOLD=3, request tile 2 -> 8 plots flash=1, 3 idle cycles, 8 plots flash=0, done pulse 20 cycles after the transfer edge.
REQ-039 NUM_TILES=3: req_tile=3 -> req_ready drops for zero cycles, no plot, no done, and the FSM remains in IDLE.
REQ-040 req_valid held high with tile 1 during the tile-2 sequence -> tile 1 is accepted in the done cycle; its flash begins in the next cycle.
REQ-041 resetn=0 during the 5th plot of FLASH_DRAW -> at the next cycle plot=0, busy=0, state=BOOT; a later start redraws all tiles.
REQ-042 HOLD_CYCLES=1, W=H=1 -> flash plot, 1 hold cycle, restore plot, done exactly 4 cycles after the transfer.
